// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Uses SIGNED_DIV_EN for the optional signed mode.
package div_pkg;

  localparam int unsigned WIDTH = 8;
  localparam logic [WIDTH-1:0] DIV0_QUOT = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StZchk,
    StRun,
    StFix,
    StDone
  } div_state_e;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/eight_bit_seq_divider_if.sv
// Start/done handshake bundle between the control FSM (master) and the divider (slave).
// SIGNED_DIV_EN adds is_signed and overflow.
interface eight_bit_seq_divider_if;
  import div_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
`ifdef SIGNED_DIV_EN
  logic             is_signed;
  logic             overflow;
`endif

  modport master (
    output start, dividend, divisor,
`ifdef SIGNED_DIV_EN
    output is_signed,
    input  overflow,
`endif
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
`ifdef SIGNED_DIV_EN
    input  is_signed,
    output overflow,
`endif
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/div_addsub_step.sv
// One non-restoring step: a + b or a - b in two's complement, plus the result sign.
module div_addsub_step #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         sign_o
);

  assign sum_o  = sub_i ? (a_i - b_i) : (a_i + b_i);
  assign sign_o = sum_o[W-1];

endmodule

// File: rtl/eight_bit_seq_divider.sv
// Non-restoring sequential divider, one quotient bit per clock, start/done handshake.
// SIGNED_DIV_EN enables truncating signed division with overflow flag.
module eight_bit_seq_divider #(
  parameter int unsigned WIDTH = div_pkg::WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  eight_bit_seq_divider_if.slave bus
);
  import div_pkg::*;

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned RW   = WIDTH + 1;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, q_q, q_d;
  logic [RW-1:0]    r_q, r_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
`ifdef SIGNED_DIV_EN
  logic             sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, ovf_q, ovf_d;
`endif

  logic [RW-1:0] step_a, step_b, step_sum, r_fix;
  logic          step_sub, step_sign;

  // RUN feeds the shifted partial remainder; FIX reuses the adder for the final restore.
  assign step_a   = (state_q == StFix) ? r_q : {r_q[RW-2:0], q_q[WIDTH-1]};
  assign step_sub = (state_q == StFix) ? 1'b0 : ~r_q[RW-1];
  assign step_b   = {1'b0, dvs_q};

  div_addsub_step #(
    .W (RW)
  ) u_step (
    .a_i    (step_a),
    .b_i    (step_b),
    .sub_i  (step_sub),
    .sum_o  (step_sum),
    .sign_o (step_sign)
  );

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    r_fix   = r_q[RW-1] ? step_sum : r_q;
`ifdef SIGNED_DIV_EN
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          done_d  = 1'b0;
          dbz_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StZchk;
`ifdef SIGNED_DIV_EN
          sgn_d   = bus.is_signed;
          ovf_d   = 1'b0;
`endif
        end
      end
      StZchk: begin
        r_d   = '0;
        q_d   = dvd_q;
        cnt_d = '0;
`ifdef SIGNED_DIV_EN
        qneg_d = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
        rneg_d = sgn_q & dvd_q[WIDTH-1];
        if (sgn_q) begin
          q_d   = abs_val(dvd_q);
          dvs_d = abs_val(dvs_q);
        end
`endif
        // Zero divisor still passes through FIX so done lands two edges after start.
        if (dvs_q == '0) begin
          busy_d  = 1'b0;
          state_d = StFix;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        r_d   = step_sum;
        q_d   = {q_q[WIDTH-2:0], ~step_sign};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          busy_d  = 1'b0;
          state_d = StFix;
        end
      end
      StFix: begin
        done_d  = 1'b1;
        state_d = StDone;
        if (dvs_q == '0) begin
          quot_d = DIV0_QUOT;
          rem_d  = dvd_q;
          dbz_d  = 1'b1;
        end else begin
          r_d    = r_fix;
          quot_d = q_q;
          rem_d  = r_fix[WIDTH-1:0];
`ifdef SIGNED_DIV_EN
          if (qneg_q) quot_d = -q_q;
          if (rneg_q) rem_d = -r_fix[WIDTH-1:0];
          ovf_d = sgn_q & ~qneg_q & q_q[WIDTH-1];
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
`ifdef SIGNED_DIV_EN
  assign bus.overflow    = ovf_q;
`endif

endmodule
